stream_arb_mux: RTL

- Registered N:1 stream multiplexer with a built-in arbiter; successor to the combinational select-driven mux.
- Channels present valid/ready streams. The block picks one each cycle by fixed-priority or round-robin policy.
- Optionally locks onto a channel for a whole packet, and registers the winner into a single output stage with backpressure.
- Sits between multiple producers (ADC channels, UART/SPI frame sources) and one shared consumer.

---
 rtl/stream_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/stream_arb_mux.sv | 124 ++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// Shared types and constants for the stream arbitration blocks.
package stream_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: picks one requester by fixed priority (lowest index)
// or round-robin (first request at or after ptr, wrapping).
module rr_arbiter
    import stream_pkg::*;
#(
    parameter int  CHANNELS = 4,
    parameter int  RR_MODE  = ARB_RR,
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic [CHANNELS-1:0] grant,
    output logic [SEL_W-1:0]    idx,
    output logic                found
);

    // Scan from the farthest offset down so the nearest request is written last.
    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            j = (RR_MODE == ARB_RR) ? (int'(ptr) + k) % CHANNELS : k;
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = SEL_W'(j);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_arb_mux.sv
// Registered N:1 stream mux with built-in arbiter, optional packet lock,
// and a single backpressured output stage.
module stream_arb_mux
    import stream_pkg::*;
#(
    parameter int  CHANNELS    = 4,
    parameter int  WIDTH       = 8,
    parameter int  RR_MODE     = 1,
    parameter int  PACKET_MODE = 0,
    localparam int SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [WIDTH*CHANNELS-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS-1:0]       in_last,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    output logic                      out_last,
    output logic [SEL_W-1:0]          out_sel,
    input  logic                      out_ready,
    output logic                      dbg_locked
);

    // Handshake rule: a beat moves on a channel only in a cycle where its
    // valid and ready are both high; ready never waits on data contents.

    lock_state_t         lock_q, lock_d;
    logic [SEL_W-1:0]    lock_ch_q, lock_ch_d;
    logic [SEL_W-1:0]    ptr_q;
    logic [CHANNELS-1:0] lock_mask, req, grant;
    logic [SEL_W-1:0]    win;
    logic                any_req, load, hs;
    logic [WIDTH-1:0]    win_data;
    logic                win_last;

    assign load = reset && enable && (!out_valid || out_ready);

    always_comb begin
        lock_mask = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            lock_mask[i] = (lock_q == UNLOCKED) || (SEL_W'(i) == lock_ch_q);
        end
    end

    assign req = in_valid & lock_mask;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .RR_MODE  (RR_MODE)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (win),
        .found (any_req)
    );

    assign in_ready   = load ? grant : '0;
    assign hs         = load && any_req;
    assign dbg_locked = (lock_q == LOCKED);

    always_comb begin
        win_data = '0;
        win_last = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) begin
                win_data = in_data[i*WIDTH +: WIDTH];
                win_last = in_last[i];
            end
        end
    end

    // Lock FSM: a first beat without last pins the grant to that channel.
    always_comb begin
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        if (PACKET_MODE != 0 && hs) begin
            if (lock_q == UNLOCKED && !win_last) begin
                lock_d    = LOCKED;
                lock_ch_d = win;
            end else if (lock_q == LOCKED && win_last) begin
                lock_d = UNLOCKED;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_q    <= UNLOCKED;
            lock_ch_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else if (hs && (PACKET_MODE == 0 || win_last)) begin
            ptr_q <= SEL_W'((int'(win) + 1) % CHANNELS);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
        end else if (hs) begin
            out_valid <= 1'b1;
            out_data  <= win_data;
            out_last  <= win_last;
            out_sel   <= win;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
